controle_navegacao: RTL and testbench



---
 rtl/nav_pkg.sv | 27 ++
 rtl/controle_navegacao_if.sv | 25 ++
 rtl/controle_navegacao.sv | 124 ++++++++++++
 tb/tb_controle_navegacao.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nav_pkg.sv
// Shared definitions for the pipe-cleaner robot navigation slice:
// controller state encoding, orientation codes and turn-sequence lengths.
package nav_pkg;

    // Controller states; PARADO must stay at zero so the reset value is the idle state.
    typedef enum logic [2:0] {
        PARADO  = 3'd0,
        AVALIA  = 3'd1,
        GIRA    = 3'd2,
        AVANCA  = 3'd3,
        REMOVE  = 3'd4,
        TRAVADO = 3'd5
    } estado_t;

    // Heading codes used by the orientation tracker fed from girar.
    typedef enum logic [2:0] {
        NORTE = 3'b001,
        OESTE = 3'b010,
        LESTE = 3'b011,
        SUL   = 3'b100
    } orient_t;

    // A left turn is one girar cycle; a right turn is three left turns in a row.
    localparam logic [1:0] VOLTAS_ESQUERDA = 2'd1;
    localparam logic [1:0] VOLTAS_DIREITA  = 2'd3;

endpackage

// File: rtl/controle_navegacao_if.sv
// Sensor / action bundle between the navigation controller and its environment.
// The slave side is the controller; the master side drives the sensors.
interface controle_navegacao_if;
    import nav_pkg::*;

    logic iniciar;
    logic head;
    logic left;
    logic lixo;
    logic girar;
    logic avancar;
    logic remover;
    logic travado;

    modport master (
        output iniciar, head, left, lixo,
        input  girar, avancar, remover, travado
    );

    modport slave (
        input  iniciar, head, left, lixo,
        output girar, avancar, remover, travado
    );

endinterface

// File: rtl/controle_navegacao.sv
// Navigation controller: left-hand wall follower with debris removal and
// stuck detection. Moore machine; every action output is a decode of the
// registered state, so an asynchronous reset drops them immediately.
module controle_navegacao
    import nav_pkg::*;
#(
    parameter int REMOVE_CYCLES = 4,
    parameter int STUCK_TURNS   = 8
) (
    input  logic                   clockc3,
    input  logic                   reset,
    controle_navegacao_if.slave    nav_bus
);

    localparam int GW = $clog2(STUCK_TURNS + 1);

    localparam logic [GW-1:0] GIRO_LIMITE = GW'(STUCK_TURNS);
    localparam logic [GW-1:0] GIRO_UM     = GW'(1);
    localparam logic [3:0]    REM_CARGA   = 4'(REMOVE_CYCLES);

    estado_t         r_estado;
    logic            r_ja_avancou;
    logic [1:0]      r_voltas;
    logic [3:0]      r_cnt_rem;
    logic [GW-1:0]   r_cnt_giro;

    estado_t         w_estado_prox;
    logic            w_ja_avancou_prox;
    logic [1:0]      w_voltas_prox;
    logic [3:0]      w_cnt_rem_prox;
    logic [GW-1:0]   w_cnt_giro_prox;

    // State and counter registers, cleared asynchronously by reset.
    always_ff @(posedge clockc3 or posedge reset) begin
        if (reset) begin
            r_estado     <= PARADO;
            r_ja_avancou <= 1'b0;
            r_voltas     <= 2'd0;
            r_cnt_rem    <= 4'd0;
            r_cnt_giro   <= '0;
        end else begin
            // NOTE: non-blocking here so every register samples the pre-edge values.
            r_estado     <= w_estado_prox;
            r_ja_avancou <= w_ja_avancou_prox;
            r_voltas     <= w_voltas_prox;
            r_cnt_rem    <= w_cnt_rem_prox;
            r_cnt_giro   <= w_cnt_giro_prox;
        end
    end

    // Next-state and counter update: sensors only matter in AVALIA, iniciar only in PARADO.
    always_comb begin
        // NOTE: hold-current defaults first so no path leaves a variable unassigned (no latches).
        w_estado_prox     = r_estado;
        w_ja_avancou_prox = r_ja_avancou;
        w_voltas_prox     = r_voltas;
        w_cnt_rem_prox    = r_cnt_rem;
        w_cnt_giro_prox   = r_cnt_giro;

        case (r_estado)
            PARADO: begin
                if (nav_bus.iniciar) begin
                    w_estado_prox = AVALIA;
                end
            end

            AVALIA: begin
                if (r_cnt_giro >= GIRO_LIMITE) begin
                    w_estado_prox = TRAVADO;
                end else if (nav_bus.lixo) begin
                    w_estado_prox  = REMOVE;
                    w_cnt_rem_prox = REM_CARGA;
                end else if (!nav_bus.left && r_ja_avancou) begin
                    // Wall on the left vanished after a step: follow it round the corner.
                    w_estado_prox     = GIRA;
                    w_voltas_prox     = VOLTAS_ESQUERDA;
                    w_ja_avancou_prox = 1'b0;
                end else if (!nav_bus.head) begin
                    w_estado_prox = AVANCA;
                end else begin
                    // Blocked ahead: turn right as three left turns.
                    w_estado_prox = GIRA;
                    w_voltas_prox = VOLTAS_DIREITA;
                end
            end

            GIRA: begin
                w_voltas_prox   = r_voltas - 2'd1;
                w_cnt_giro_prox = (r_cnt_giro >= GIRO_LIMITE) ? GIRO_LIMITE
                                                              : r_cnt_giro + GIRO_UM;
                if (r_voltas == 2'd1) begin
                    w_estado_prox = AVALIA;
                end
            end

            AVANCA: begin
                w_ja_avancou_prox = 1'b1;
                w_cnt_giro_prox   = '0;
                w_estado_prox     = AVALIA;
            end

            REMOVE: begin
                w_cnt_rem_prox = r_cnt_rem - 4'd1;
                if (r_cnt_rem == 4'd1) begin
                    w_estado_prox = AVALIA;
                end
            end

            TRAVADO: begin
                w_estado_prox = TRAVADO;
            end

            default: begin
                w_estado_prox = PARADO;
            end
        endcase
    end

    assign nav_bus.girar   = (r_estado == GIRA);
    assign nav_bus.avancar = (r_estado == AVANCA);
    assign nav_bus.remover = (r_estado == REMOVE);
    assign nav_bus.travado = (r_estado == TRAVADO);

endmodule

// File: tb/tb_controle_navegacao.sv
// Bench for controle_navegacao: a driver issues one sensor decision per
// AVALIA slot and pushes the action a wall-follower model predicts; a
// monitor measures each output burst and compares it against the queue.
module tb_controle_navegacao;
    import nav_pkg::*;

    localparam int REM   = 4;
    localparam int STUCK = 8;

    logic clockc3;
    logic reset;

    controle_navegacao_if nav_bus ();

    controle_navegacao #(
        .REMOVE_CYCLES (REM),
        .STUCK_TURNS   (STUCK)
    ) dut (
        .clockc3 (clockc3),
        .reset   (reset),
        .nav_bus (nav_bus)
    );

    initial clockc3 = 1'b0;
    always #5 clockc3 = ~clockc3;

    typedef enum int {K_NONE, K_GIRAR, K_AVANCAR, K_REMOVER, K_TRAVADO} kind_e;

    typedef struct {
        kind_e   kind;
        int      len;
        orient_t hd;
    } act_t;

    act_t exp_q[$];
    int   n_vec  = 0;
    int   n_err  = 0;
    bit   mon_en = 1'b0;

    // Robot-level model: advanced-since-turn flag, turns since last advance, heading.
    bit      m_ja;
    int      m_turns;
    orient_t m_hd;

    function automatic orient_t turn_left(input orient_t o);
        case (o)
            NORTE:   return OESTE;
            OESTE:   return SUL;
            SUL:     return LESTE;
            default: return NORTE;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic garbage();
        nav_bus.iniciar = 1'($urandom);
        nav_bus.head    = 1'($urandom);
        nav_bus.left    = 1'($urandom);
        nav_bus.lixo    = 1'($urandom);
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        reset  = 1'b1;
        #1;
        check("reset_girar",   int'(nav_bus.girar),   0);
        check("reset_avancar", int'(nav_bus.avancar), 0);
        check("reset_remover", int'(nav_bus.remover), 0);
        check("reset_travado", int'(nav_bus.travado), 0);
        check("pending_actions", exp_q.size(), 0);
        exp_q.delete();
        m_ja    = 1'b0;
        m_turns = 0;
        m_hd    = NORTE;
        @(negedge clockc3);
        @(negedge clockc3);
        reset = 1'b0;
        repeat (8) begin
            garbage();
            nav_bus.iniciar = 1'b0;
            @(negedge clockc3);
            check("idle_until_iniciar",
                  int'({nav_bus.girar, nav_bus.avancar, nav_bus.remover, nav_bus.travado}), 0);
        end
        mon_en = 1'b1;
    endtask

    // Called at a negedge in PARADO; returns at the negedge inside the first AVALIA.
    task automatic start();
        nav_bus.iniciar = 1'b1;
        @(negedge clockc3);
        nav_bus.iniciar = 1'b0;
    endtask

    // Called at a negedge in AVALIA; returns at the negedge inside the next AVALIA.
    task automatic decide(input logic h, input logic l, input logic x);
        act_t a;
        nav_bus.iniciar = 1'($urandom);
        nav_bus.head    = h;
        nav_bus.left    = l;
        nav_bus.lixo    = x;
        if (m_turns >= STUCK) begin
            a.kind = K_TRAVADO;
            a.len  = 0;
            a.hd   = m_hd;
            exp_q.push_back(a);
            repeat (12) begin
                @(negedge clockc3);
                garbage();
            end
            do_reset();
            start();
            return;
        end
        if (x) begin
            a.kind = K_REMOVER;
            a.len  = REM;
        end else if (!l && m_ja) begin
            a.kind  = K_GIRAR;
            a.len   = 1;
            m_ja    = 1'b0;
            m_turns = m_turns + 1;
            m_hd    = turn_left(m_hd);
        end else if (!h) begin
            a.kind  = K_AVANCAR;
            a.len   = 1;
            m_ja    = 1'b1;
            m_turns = 0;
        end else begin
            a.kind  = K_GIRAR;
            a.len   = 3;
            m_turns = m_turns + 3;
            m_hd    = turn_left(turn_left(turn_left(m_hd)));
        end
        a.hd = m_hd;
        exp_q.push_back(a);
        repeat (a.len) begin
            @(negedge clockc3);
            garbage();
        end
        @(negedge clockc3);
    endtask

    // Monitor: measures bursts, the idle AVALIA gap and the heading implied by girar.
    initial begin : monitor
        kind_e   cur;
        kind_e   obs;
        int      len;
        int      gap;
        int      n_act;
        bit      have_prev;
        orient_t hd;
        act_t    e;
        cur = K_NONE; len = 0; gap = 0; have_prev = 1'b0; hd = NORTE;
        forever begin
            @(negedge clockc3);
            if (reset || !mon_en) begin
                cur = K_NONE; len = 0; gap = 0; have_prev = 1'b0; hd = NORTE;
            end else begin
                n_act = int'(nav_bus.girar) + int'(nav_bus.avancar) + int'(nav_bus.remover);
                if (nav_bus.travado) begin
                    obs = K_TRAVADO;
                    check("travado_actions_low", n_act, 0);
                end else begin
                    check("single_action", (n_act <= 1) ? 1 : 0, 1);
                    obs = nav_bus.girar   ? K_GIRAR   :
                          nav_bus.avancar ? K_AVANCAR :
                          nav_bus.remover ? K_REMOVER : K_NONE;
                end
                if (obs == cur && cur != K_NONE) begin
                    len++;
                end else begin
                    if (cur != K_NONE && cur != K_TRAVADO) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_action", int'(cur), int'(K_NONE));
                        end else begin
                            e = exp_q.pop_front();
                            check("action_kind", int'(cur), int'(e.kind));
                            check("action_len", len, e.len);
                            check("heading", int'(hd), int'(e.hd));
                        end
                        check("idle_after_action", int'(obs), int'(K_NONE));
                        have_prev = 1'b1;
                        gap = 0;
                    end
                    if (obs != K_NONE) begin
                        if (have_prev) check("avalia_gap", gap, 1);
                        if (obs == K_TRAVADO) begin
                            if (exp_q.size() == 0) begin
                                check("unexpected_travado", int'(obs), int'(K_NONE));
                            end else begin
                                e = exp_q.pop_front();
                                check("travado_entry", int'(obs), int'(e.kind));
                            end
                        end
                        cur = obs;
                        len = 1;
                    end else begin
                        cur = K_NONE;
                        gap++;
                    end
                end
                if (obs == K_GIRAR) hd = turn_left(hd);
            end
        end
    end

    initial begin : driver
        reset           = 1'b0;
        nav_bus.iniciar = 1'b0;
        nav_bus.head    = 1'b0;
        nav_bus.left    = 1'b0;
        nav_bus.lixo    = 1'b0;
        #1;
        do_reset();
        start();

        // Straight corridor, corner follow, turn-around, debris.
        repeat (3) decide(1'b0, 1'b1, 1'b0);
        decide(1'b0, 1'b0, 1'b0);
        decide(1'b0, 1'b0, 1'b0);
        decide(1'b1, 1'b1, 1'b0);
        decide(1'b0, 1'b1, 1'b1);
        decide(1'b0, 1'b1, 1'b1);
        decide(1'b0, 1'b1, 1'b0);

        // Boxed in: three turn-arounds, then stuck (the fourth call resets and restarts).
        do_reset();
        start();
        repeat (4) decide(1'b1, 1'b1, 1'b0);

        // Reset during the second girar cycle of a right turn.
        mon_en          = 1'b0;
        nav_bus.head    = 1'b1;
        nav_bus.left    = 1'b1;
        nav_bus.lixo    = 1'b0;
        nav_bus.iniciar = 1'b0;
        @(posedge clockc3);
        @(posedge clockc3);
        #2;
        check("girar_before_reset", int'(nav_bus.girar), 1);
        do_reset();
        start();

        // Random walk through the maze.
        repeat (80) begin
            decide(1'($urandom), 1'($urandom), ($urandom_range(0, 6) == 0));
        end

        #1;
        mon_en = 1'b0;
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
